// File: rtl/quantize_stream.sv
// quantize_stream: streaming JPEG quantizer.
// LANES signed Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS coefficients per beat are
// multiplied by a luma/chroma reciprocal, rounded half away from zero and
// saturated to OUT_WIDTH signed bits. The pipeline has two stages and one
// global stall enable, so back-pressure freezes every register at once.

// One lane. S1 holds the product; S2 holds the rounded, saturated result.
module quantize_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] coef,
  input  logic [15:0]                  recip,
  output logic signed [OUT_WIDTH-1:0]  q,
  output logic                         sat
);
  localparam int PW = DATA_WIDTH + 17;
  localparam int SH = FRAC_BITS + 16;
  localparam logic [PW-1:0] RND     = PW'(1) << (FRAC_BITS + 15);
  localparam logic [PW-1:0] POS_LIM = PW'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
  localparam logic [PW-1:0] NEG_LIM = PW'(64'd1 << (OUT_WIDTH - 1));

  logic signed [PW-1:0] coef_x, r_x, prod;
  logic                 neg;
  logic [PW-1:0]        mag, rnd, qmag;
  logic signed [OUT_WIDTH-1:0] q_next;

  // Reciprocal is unsigned; widen it with a zero sign bit before the signed multiply.
  assign coef_x = PW'(coef);
  assign r_x    = PW'($signed({1'b0, recip}));

  // S1: register the full-precision product.
  always_ff @(posedge clk) begin
    if (!rst_n)  prod <= '0;
    else if (en) prod <= coef_x * r_x;
  end

  // Round the magnitude, then reapply the sign and clamp to the output range.
  always_comb begin
    neg    = prod[PW-1];
    mag    = neg ? PW'(-prod) : PW'(prod);
    rnd    = mag + RND;
    qmag   = rnd >> SH;
    sat    = neg ? (qmag > NEG_LIM) : (qmag > POS_LIM);
    q_next = neg ? -qmag[OUT_WIDTH-1:0] : qmag[OUT_WIDTH-1:0];
    if (sat) q_next = neg ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end

  // S2: register the final lane value.
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= q_next;
  end
endmodule

module quantize_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int LANES      = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_chroma,
  input  logic [LANES*DATA_WIDTH-1:0]     in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES*OUT_WIDTH-1:0]      out_data,
  output logic                            out_last,
  output logic                            out_sat
);
  localparam int BEATS  = 64 / LANES;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int STAGES = 2;

  // JPEG Annex K tables, raster order.
  localparam int LUMA_Q [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68,109,103, 77,
    24, 35, 55, 64, 81,104,113, 92,
    49, 64, 78, 87,103,121,120,101,
    72, 92, 95, 98,112,100,103, 99};
  localparam int CHROMA_Q [64] = '{
    17, 18, 24, 47, 99, 99, 99, 99,
    18, 21, 26, 66, 99, 99, 99, 99,
    24, 26, 56, 99, 99, 99, 99, 99,
    47, 66, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99};

  // round(65536/q), ties up; only ever evaluated on constants.
  function automatic logic [15:0] recip(input int qv);
    return 16'((131072 + qv) / (2 * qv));
  endfunction

  logic [BW-1:0]              beat_idx, s1_beat;
  logic                       tbl_sel, cur_tbl, in_last, s1_last;
  logic                       en, hs, sat_acc, beat_sat;
  logic [STAGES:1]            vld_pipe;
  logic [LANES-1:0]           lane_sat;
  logic [LANES-1:0][15:0]     lane_r;

  assign en        = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];
  assign hs        = in_valid && en;
  assign in_last   = (beat_idx == BW'(BEATS - 1));
  assign s1_last   = (s1_beat == BW'(BEATS - 1));
  // Beat 0 uses in_chroma directly: tbl_sel only picks it up on that same edge.
  assign cur_tbl   = (beat_idx == '0) ? in_chroma : tbl_sel;
  assign beat_sat  = |lane_sat;

  // Input-side beat counter and per-block table latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_idx <= '0;
      tbl_sel  <= 1'b0;
    end else if (hs) begin
      beat_idx <= in_last ? '0 : beat_idx + BW'(1);
      if (beat_idx == '0) tbl_sel <= in_chroma;
    end
  end

  // Pipeline valid/metadata, block-level saturation accumulation and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_beat  <= '0;
      out_last <= 1'b0;
      out_sat  <= 1'b0;
      sat_acc  <= 1'b0;
    end else if (en) begin
      vld_pipe[1] <= in_valid;
      s1_beat     <= beat_idx;
      vld_pipe[2] <= vld_pipe[1];
      out_last    <= vld_pipe[1] && s1_last;
      out_sat     <= vld_pipe[1] && s1_last && (sat_acc || beat_sat);
      if (vld_pipe[1]) sat_acc <= s1_last ? 1'b0 : (sat_acc || beat_sat);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [BEATS-1:0][15:0] rom_l, rom_c;
    for (genvar b = 0; b < BEATS; b++) begin : g_rom
      assign rom_l[b] = recip(LUMA_Q[b*LANES + k]);
      assign rom_c[b] = recip(CHROMA_Q[b*LANES + k]);
    end
    assign lane_r[k] = cur_tbl ? rom_c[beat_idx] : rom_l[beat_idx];

    quantize_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .OUT_WIDTH  (OUT_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .coef  (in_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .recip (lane_r[k]),
      .q     (out_data[k*OUT_WIDTH +: OUT_WIDTH]),
      .sat   (lane_sat[k])
    );
  end
endmodule

// File: tb/tb_quantize_stream.sv
// Bench for quantize_stream: a 16-bit and an 8-bit output instance share one
// input stream; a scoreboard checks every output beat of both.
module tb_quantize_stream;
  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_chroma, out_ready;
  logic [255:0] in_data;
  logic         in_ready_a, out_valid_a, out_last_a, out_sat_a;
  logic [127:0] out_data_a;
  logic         in_ready_b, out_valid_b, out_last_b, out_sat_b;
  logic [63:0]  out_data_b;

  always #5 clk = ~clk;

  quantize_stream #(.DATA_WIDTH(32), .FRAC_BITS(16), .OUT_WIDTH(16), .LANES(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_chroma(in_chroma), .in_data(in_data), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_last(out_last_a), .out_sat(out_sat_a));

  quantize_stream #(.DATA_WIDTH(32), .FRAC_BITS(16), .OUT_WIDTH(8), .LANES(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_chroma(in_chroma), .in_data(in_data), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_last(out_last_b), .out_sat(out_sat_b));

  int n_checks = 0, n_errors = 0, cyc = 0;

  int LQ [64] = '{16,11,10,16,24,40,51,61, 12,12,14,19,26,58,60,55,
                  14,13,16,24,40,57,69,56, 14,17,22,29,51,87,80,62,
                  18,22,37,56,68,109,103,77, 24,35,55,64,81,104,113,92,
                  49,64,78,87,103,121,120,101, 72,92,95,98,112,100,103,99};
  int CQ [64] = '{17,18,24,47,99,99,99,99, 18,21,26,66,99,99,99,99,
                  24,26,56,99,99,99,99,99, 47,66,99,99,99,99,99,99,
                  99,99,99,99,99,99,99,99, 99,99,99,99,99,99,99,99,
                  99,99,99,99,99,99,99,99, 99,99,99,99,99,99,99,99};

  typedef struct {
    logic [127:0] d16; logic [63:0] d8;
    logic last; logic sat16; logic sat8;
    int acc; bit lchk;
  } exp_t;
  exp_t expq[$];

  typedef struct {
    logic [31:0] coef; int idx; bit chroma; bit toggle;
    int e16; int e8; bit s8;
  } vec_t;
  vec_t vt [14];

  logic [31:0] blk_c [64];
  int          blk_e16 [64], blk_e8 [64];
  bit          blk_sat16, blk_sat8;

  always @(negedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Golden arithmetic, straight from the definition.
  function automatic void qz(input longint c, input longint r, input int ow, output int v, output bit s);
    longint p, m, q, vv, mx, mn;
    bit neg;
    p = c * r; neg = (p < 0);
    m = (neg ? -p : p) + 64'sd2147483648;
    q = m >>> 32;
    vv = neg ? -q : q;
    mx = (64'sd1 <<< (ow - 1)) - 1; mn = -(64'sd1 <<< (ow - 1));
    s = 1'b0; v = int'(vv);
    if (vv > mx) begin v = int'(mx); s = 1'b1; end
    else if (vv < mn) begin v = int'(mn); s = 1'b1; end
  endfunction

  task automatic model_block(input bit ch);
    int v; bit s; longint r;
    blk_sat16 = 0; blk_sat8 = 0;
    for (int i = 0; i < 64; i++) begin
      r = (131072 + (ch ? CQ[i] : LQ[i])) / (2 * (ch ? CQ[i] : LQ[i]));
      qz(longint'($signed(blk_c[i])), r, 16, v, s); blk_e16[i] = v; blk_sat16 |= s;
      qz(longint'($signed(blk_c[i])), r, 8, v, s);  blk_e8[i] = v;  blk_sat8 |= s;
    end
  endtask

  task automatic clear_block();
    for (int i = 0; i < 64; i++) begin blk_c[i] = '0; blk_e16[i] = 0; blk_e8[i] = 0; end
    blk_sat16 = 0; blk_sat8 = 0;
  endtask

  task automatic send_beat(input int b, input bit ch, input bit push, input bit lchk);
    bit hs = 0; int acc = 0; exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_chroma = ch;
    for (int k = 0; k < 8; k++) in_data[k*32 +: 32] = blk_c[b*8 + k];
    for (int t = 0; t < 200; t++) begin
      #1;
      if (in_ready_a) begin hs = 1; acc = cyc; break; end
      @(negedge clk);
    end
    if (!hs) chk("in_handshake_timeout", 0, 1);
    if (push) begin
      for (int k = 0; k < 8; k++) begin
        e.d16[k*16 +: 16] = 16'(blk_e16[b*8 + k]);
        e.d8[k*8 +: 8]    = 8'(blk_e8[b*8 + k]);
      end
      e.last = (b == 7); e.sat16 = (b == 7) && blk_sat16; e.sat8 = (b == 7) && blk_sat8;
      e.acc = acc; e.lchk = lchk;
      expq.push_back(e);
    end
  endtask

  task automatic send_block(input bit ch, input bit tog, input bit lchk);
    for (int b = 0; b < 8; b++) send_beat(b, (tog && b > 0) ? !ch : ch, 1, lchk);
  endtask

  task automatic idle();
    @(negedge clk); in_valid = 1'b0; in_chroma = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && expq.size() != 0; t++) @(negedge clk);
    chk("drain_pending", expq.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  // Output monitor: scoreboard compare, hold-stability and latency.
  int first_seen = -1; bit stalled = 0;
  logic [194:0] sv;
  exp_t em;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin stalled = 0; first_seen = -1; end
    else begin
      if (stalled) chk("hold_stable", {out_valid_a, out_data_a, out_last_a, out_sat_a, out_data_b},
                       {1'b1, sv[193:0]});
      if (out_valid_a) begin
        if (first_seen < 0) first_seen = cyc;
        if (out_ready) begin
          if (expq.size() == 0) chk("unexpected_beat", 1, 0);
          else begin
            em = expq.pop_front();
            chk("data16", out_data_a, em.d16);
            chk("data8", out_data_b, em.d8);
            chk("last", {out_last_a, out_last_b}, {em.last, em.last});
            chk("sat16", out_sat_a, em.sat16);
            chk("sat8", out_sat_b, em.sat8);
            chk("valid_b", out_valid_b, 1);
            if (em.lchk) chk("latency", first_seen - em.acc, 2);
          end
          first_seen = -1; stalled = 0;
        end else begin
          stalled = 1;
          sv = {out_valid_a, out_data_a, out_last_a, out_sat_a, out_data_b};
        end
      end else stalled = 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // coef, idx, chroma, toggle, expected OUT16, expected OUT8, sat on OUT8
    vt[0]  = '{32'h00640000, 0,  1'b0, 1'b0,    6,    6, 1'b0}; // 100/16
    vt[1]  = '{32'h00640000, 0,  1'b1, 1'b1,    6,    6, 1'b0}; // 100/17
    vt[2]  = '{32'h0C5D0000, 63, 1'b1, 1'b1,   32,   32, 1'b0}; // 3165*662/65536
    vt[3]  = '{32'hFFF80000, 0,  1'b0, 1'b0,   -1,   -1, 1'b0}; // -0.5 tie
    vt[4]  = '{32'h00080000, 0,  1'b0, 1'b0,    1,    1, 1'b0}; // +0.5 tie
    vt[5]  = '{32'h0007FFFF, 0,  1'b0, 1'b0,    0,    0, 1'b0}; // just below tie
    vt[6]  = '{32'h0FA00000, 0,  1'b0, 1'b0,  250,  127, 1'b1}; // 4000
    vt[7]  = '{32'hF0600000, 0,  1'b0, 1'b0, -250, -128, 1'b1}; // -4000
    vt[8]  = '{32'h00370000, 1,  1'b0, 1'b0,    5,    5, 1'b0}; // 55/11, clean after sat
    vt[9]  = '{32'h03E80000, 58, 1'b0, 1'b0,   11,   11, 1'b0}; // 1000*690
    vt[10] = '{32'h00178000, 0,  1'b0, 1'b0,    1,    1, 1'b0}; // 23.5/16
    vt[11] = '{32'hFFE80000, 0,  1'b0, 1'b0,   -2,   -2, 1'b0}; // -1.5 tie
    vt[12] = '{32'hFF2E0000, 9,  1'b1, 1'b1,  -10,  -10, 1'b0}; // -210/21, luma would be -17
    vt[13] = '{32'h03DE0000, 4,  1'b1, 1'b0,   10,   10, 1'b0}; // 990/99, luma would be 41

    rst_n = 0; in_valid = 0; in_chroma = 0; in_data = '0; out_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", {out_valid_a, out_valid_b}, 0);
    chk("rst_out_data", {out_data_a, out_data_b}, 0);
    chk("rst_flags", {out_last_a, out_sat_a, out_last_b, out_sat_b}, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk); #1;
    chk("rst_in_ready", {in_ready_a, in_ready_b}, 2'b11);

    // Directed vectors, blocks sent back-to-back.
    for (int v = 0; v < 14; v++) begin
      clear_block();
      blk_c[vt[v].idx] = vt[v].coef;
      blk_e16[vt[v].idx] = vt[v].e16;
      blk_e8[vt[v].idx] = vt[v].e8;
      blk_sat8 = vt[v].s8;
      send_block(vt[v].chroma, vt[v].toggle, 1);
    end
    idle();
    drain();

    // Back-pressure: three modelled blocks, out_ready low for 5 cycles mid-stream.
    fork
      begin
        for (int j = 0; j < 3; j++) begin
          clear_block();
          for (int i = 0; i < 64; i++) blk_c[i] = 32'($urandom_range(0, 393216000)) - 32'd196608000;
          model_block(j[0]);
          send_block(j[0], 0, 0);
        end
      end
      begin
        repeat (12) @(negedge clk);
        out_ready = 0;
        repeat (2) @(negedge clk);
        #1 chk("bp_in_ready_low", in_ready_a, 0);
        repeat (3) @(negedge clk);
        out_ready = 1;
      end
    join
    idle();
    drain();

    // Reset after three accepted beats: only the already-handed-off beat 0 appears.
    clear_block();
    for (int i = 0; i < 64; i++) blk_c[i] = 32'h00640000;
    model_block(0);
    send_beat(0, 0, 1, 1);
    send_beat(1, 0, 0, 0);
    send_beat(2, 0, 0, 0);
    @(negedge clk); in_valid = 0; rst_n = 0;
    @(negedge clk); #1;
    chk("midrst_out_valid", {out_valid_a, out_valid_b}, 0);
    chk("midrst_out_data", {out_data_a, out_data_b}, 0);
    chk("midrst_flags", {out_last_a, out_sat_a, out_last_b, out_sat_b}, 0);
    chk("midrst_in_ready", in_ready_a, 1);
    rst_n = 1;

    // Fresh chroma block must start at beat 0 and use chroma throughout.
    clear_block();
    blk_c[4] = 32'h03DE0000;  blk_e16[4] = 10;  blk_e8[4] = 10;
    blk_c[9] = 32'hFF2E0000;  blk_e16[9] = -10; blk_e8[9] = -10;
    send_block(1, 0, 1);
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/quantize_stream.md
# quantize_stream

Streaming, parametrised successor to the fixed-table `quantize_array`. It accepts 8×8 DCT coefficient blocks (signed Q16.16) as a valid/ready stream of `LANES` coefficients per beat. The luma or chroma JPEG table is selected per block at runtime. Each coefficient is multiplied by a table reciprocal, rounded half away from zero, and saturated to `OUT_WIDTH` signed bits. The block sits between the DCT stage and the zigzag/entropy stage, replacing the start/done whole-block interface with a pipelined, back-pressurable stream.

## Interface
- `DATA_WIDTH`, 32: input coefficient width, signed fixed point.
- `FRAC_BITS`, 16: fractional bits of the input coefficient.
- `OUT_WIDTH`, 16: output width, signed integer, 2..16.
- `LANES`, 8: coefficients per beat; one of 1, 2, 4, 8, 16, 32, 64. `BEATS = 64/LANES`.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block can accept a beat.
- `in_chroma` in 1: table select (0 luma, 1 chroma). Sampled only on the first beat of a block.
- `in_data` in `LANES*DATA_WIDTH`: lane k at bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts the beat.
- `out_data` out `LANES*OUT_WIDTH`: lane k at bits `[k*OUT_WIDTH +: OUT_WIDTH]`.
- `out_last` out 1: beat is the last of a block.
- `out_sat` out 1: sticky flag, valid with `out_last`. Set if any coefficient of that block saturated.

## Operation
- **Coefficient order**: natural raster order. Coefficient index = `beat_idx*LANES + k`; index 0 is DC.
- **Beat counter** `beat_idx` (0..BEATS-1):
  - increments on each input handshake (`in_valid && in_ready`);
  - wraps from BEATS-1 to 0.
- **Table select**: `in_chroma` is latched into `tbl_sel` on the handshake where `beat_idx==0`. That beat and all later beats of the block use the latched value, so mid-block changes of `in_chroma` are ignored.
- **Tables**: standard JPEG Annex K luma and chroma tables (Q values 10..121). They are stored as 16-bit unsigned reciprocals `R = round(65536/Q)`, ties up, in constant ROMs. Examples: luma[0]=16 gives R=4096; luma[1]=11 gives R=5958; chroma[0]=17 gives R=3855; chroma[63]=99 gives R=662.
- **Arithmetic, per lane**:
  - `P = coef * R`, signed, `DATA_WIDTH+17` bits.
  - Magnitude `M = |P| + 2^(FRAC_BITS+15)`, then `q = M >> (FRAC_BITS+16)`.
  - Reapply the sign of `coef`.
  - Saturate to `[-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]`.
  - The result must be bit-exact to this definition; no tolerance.
- **Saturation flag**: a per-block flag ORs the lane saturation bits of every beat. It is presented on `out_sat` with `out_last`, then clears for the next block. `out_sat` is 0 on non-last beats.
- **Pipeline**: two register stages.
  - S1: product plus metadata (last, per-beat index).
  - S2: rounded, saturated data, `out_last`, `out_sat`.
- **Stall**: global enable `en = !out_valid || out_ready`; `in_ready = en`.
  - While stalled, all stage registers hold.
  - Bubbles are not compressed.

## Timing
- **Reset** (`rst_n` low at a rising edge) clears:
  - `out_valid`, `out_data`, `out_last`, `out_sat`, and S1 valid to 0;
  - `beat_idx` and `tbl_sel` to 0;
  - the accumulated saturation flag.
  
  `in_ready` is 1 in the first cycle after reset.
- **Reset mid-block**: the partial block and any in-flight beats are discarded with no output. The next accepted beat is beat 0 of a new block and samples `in_chroma`.
- **Latency**: a beat accepted at edge N appears with `out_valid=1` after edge N+2, given `out_ready=1` throughout. With continuous input and output, throughput is 1 beat/cycle.
- **Handshake**:
  - `out_data`, `out_last`, and `out_sat` remain stable while `out_valid && !out_ready`.
  - `in_valid` may be withdrawn without loss; a beat is consumed only on a handshake.
- **Simultaneous events**: a beat can enter S1 on the same edge that S2 hands off a beat; there is no dead cycle. With `en=0`, `beat_idx` does not advance even if `in_valid=1`.
- **Block boundary**: an input handshake at beat BEATS-1 and a new block's beat 0 on the next edge are legal back-to-back. `tbl_sel` updates without affecting the in-flight last beat.

## Test plan
- **Luma DC, LANES=8**: lane 0 = `0x00640000` (100.0), others 0, `in_chroma=0` → out lane0 = 6, others 0. Latency exactly 2 cycles; `out_last=0` on beats 0-6 and 1 on beat 7.
- **Chroma DC**: 100.0 at index 0 → 6. Index 63 = `0x0C5D0000` (3165.0) → round(3165·662/65536) = 32. Toggling `in_chroma` on beats 1-7 changes nothing.
- **Rounding ties**: -8.0 (`0xFFF80000`) at luma index 0 → -1 (-0.5 away from zero). +8.0 → +1. 7.9999 (`0x0007FFFF`) → 0.
- **Saturation**: `OUT_WIDTH=8` instance, 4000.0 at luma index 0 → 127 (-4000.0 → -128), `out_sat=1` on that block's last beat. The next clean block gives `out_sat=0`.
- **Backpressure**: continuous `in_valid`, `out_ready` low for 5 cycles mid-block → `in_ready` drops. Output is stable, 3 full blocks are emitted in order, with no loss or duplication against the golden model.
- **Reset mid-block**: reset after 3 accepted beats → all outputs 0, no partial output. A following chroma block yields `out_last` on its 8th beat and uses the chroma table throughout.
